// File: rtl/cc_transition_animator.sv
// 8x8 matrix frame player: steps through a fixed frame ROM in once, loop or
// ping-pong order, showing each frame for a latched number of clock cycles.
module cc_transition_animator #(
  parameter int NFRAMES = 7,
  parameter int HOLD_W  = 24,
  parameter bit INVERT  = 1'b0
) (
  input  logic              transition_animator_CLOCK_50,
  input  logic              transition_animator_RESET_InHigh,
  input  logic              transition_animator_start_in,
  input  logic              transition_animator_abort_in,
  input  logic [1:0]        transition_animator_mode_in,
  input  logic [HOLD_W-1:0] transition_animator_hold_in,
  output logic [63:0]       transition_animator_matrix_bus_out,
  output logic [2:0]        transition_animator_frame_idx_out,
  output logic              transition_animator_busy_out,
  output logic              transition_animator_done_out
);

  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  localparam logic [2:0] LAST = 3'(NFRAMES - 1);

  state_t            state_q, state_d;
  logic [2:0]        frame_q, frame_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        mode_q, mode_d;
  logic              dir_q, dir_d;
  logic [63:0]       matrix_q, matrix_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Rows 7..0 from MSB to LSB.
  function automatic logic [63:0] rom_f(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_f = 64'h2030_383C_3C38_3020;
      3'd1:    rom_f = 64'h6699_8989_B999_9966;
      3'd2:    rom_f = 64'h8142_2418_1824_4281;
      3'd3:    rom_f = 64'hFF7E_3C18_1818_3CFF;
      3'd4:    rom_f = 64'hFF18_1818_1818_18FF;
      3'd5:    rom_f = 64'hFF66_6666_6666_66FF;
      3'd6:    rom_f = 64'hFF5A_5A5A_5A5A_5AFF;
      default: rom_f = 64'h0;
    endcase
  endfunction

  always_ff @(posedge transition_animator_CLOCK_50 or posedge transition_animator_RESET_InHigh) begin
    if (transition_animator_RESET_InHigh) begin
      state_q  <= IDLE;
      frame_q  <= 3'd0;
      cnt_q    <= '0;
      hold_q   <= '0;
      mode_q   <= 2'b00;
      dir_q    <= 1'b0;
      matrix_q <= 64'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      matrix_q <= matrix_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (transition_animator_start_in && !transition_animator_abort_in) begin
          state_d = SHOW;
          mode_d  = transition_animator_mode_in;
          hold_d  = (transition_animator_hold_in == '0) ? HOLD_W'(1) : transition_animator_hold_in;
          frame_d = 3'd0;
          cnt_d   = '0;
          dir_d   = 1'b0;
        end
      end
      SHOW: begin
        if (transition_animator_abort_in) begin
          state_d = IDLE;
          frame_d = 3'd0;
          cnt_d   = '0;
        end else if (cnt_q == hold_q - HOLD_W'(1)) begin
          cnt_d = '0;
          case (mode_q)
            2'b01: frame_d = (frame_q == LAST) ? 3'd0 : frame_q + 3'd1;
            2'b10: begin
              // dir_q=0 counts up; end frames turn around without repeating.
              if (!dir_q) begin
                if (frame_q == LAST) begin
                  if (LAST != 3'd0) begin
                    frame_d = frame_q - 3'd1;
                    dir_d   = 1'b1;
                  end
                end else begin
                  frame_d = frame_q + 3'd1;
                end
              end else begin
                if (frame_q == 3'd0) begin
                  if (LAST != 3'd0) frame_d = 3'd1;
                  dir_d = 1'b0;
                end else begin
                  frame_d = frame_q - 3'd1;
                end
              end
            end
            default: begin
              if (frame_q == LAST) begin
                state_d = DONE;
                frame_d = 3'd0;
              end else begin
                frame_d = frame_q + 3'd1;
              end
            end
          endcase
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        frame_d = 3'd0;
      end
      default: state_d = IDLE;
    endcase

    matrix_d = (state_d == SHOW) ? (rom_f(frame_d) ^ {64{INVERT}}) : 64'h0;
    busy_d   = (state_d == SHOW);
    done_d   = (state_d == DONE);
  end

  assign transition_animator_matrix_bus_out = matrix_q;
  assign transition_animator_frame_idx_out  = frame_q;
  assign transition_animator_busy_out       = busy_q;
  assign transition_animator_done_out       = done_q;

endmodule

// File: tb/tb_cc_transition_animator.sv
// Bench for cc_transition_animator: three parameterisations driven in lockstep
// and compared against a frame-timeline reference model.
module tb_cc_transition_animator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [1:0]  mode;
  logic [23:0] hold;
  logic [63:0] mat_o  [3];
  logic [2:0]  fidx_o [3];
  logic        busy_o [3];
  logic        done_o [3];

  always #5 clk = ~clk;

  cc_transition_animator #(.NFRAMES(7)) dut7 (
    .transition_animator_CLOCK_50(clk), .transition_animator_RESET_InHigh(rst),
    .transition_animator_start_in(start), .transition_animator_abort_in(abort),
    .transition_animator_mode_in(mode), .transition_animator_hold_in(hold),
    .transition_animator_matrix_bus_out(mat_o[0]), .transition_animator_frame_idx_out(fidx_o[0]),
    .transition_animator_busy_out(busy_o[0]), .transition_animator_done_out(done_o[0]));

  cc_transition_animator #(.NFRAMES(4), .HOLD_W(8), .INVERT(1'b1)) dut4 (
    .transition_animator_CLOCK_50(clk), .transition_animator_RESET_InHigh(rst),
    .transition_animator_start_in(start), .transition_animator_abort_in(abort),
    .transition_animator_mode_in(mode), .transition_animator_hold_in(hold[7:0]),
    .transition_animator_matrix_bus_out(mat_o[1]), .transition_animator_frame_idx_out(fidx_o[1]),
    .transition_animator_busy_out(busy_o[1]), .transition_animator_done_out(done_o[1]));

  cc_transition_animator #(.NFRAMES(1), .HOLD_W(4)) dut1 (
    .transition_animator_CLOCK_50(clk), .transition_animator_RESET_InHigh(rst),
    .transition_animator_start_in(start), .transition_animator_abort_in(abort),
    .transition_animator_mode_in(mode), .transition_animator_hold_in(hold[3:0]),
    .transition_animator_matrix_bus_out(mat_o[2]), .transition_animator_frame_idx_out(fidx_o[2]),
    .transition_animator_busy_out(busy_o[2]), .transition_animator_done_out(done_o[2]));

  int NF  [3] = '{7, 4, 1};
  int HW  [3] = '{24, 8, 4};
  bit INV [3] = '{1'b0, 1'b1, 1'b0};
  logic [63:0] ROM [7] = '{64'h2030383C3C383020, 64'h66998989B9999966,
                           64'h8142241818244281, 64'hFF7E3C1818183CFF,
                           64'hFF181818181818FF, 64'hFF666666666666FF,
                           64'hFF5A5A5A5A5A5AFF};

  int total = 0;
  int bad   = 0;

  // Reference model: playback is "t cycles since start" with latched mode/hold.
  bit m_act [3];
  bit m_done[3];
  int m_t   [3];
  int m_mode[3];
  int m_hold[3];

  function automatic int frame_at(input int n, input int h, input int md, input int t);
    int p;
    p = t / h;
    if (md == 1) return p % n;
    if (md == 2) begin
      if (n == 1) return 0;
      p = p % (2 * n - 2);
      return (p < n) ? p : (2 * n - 2 - p);
    end
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_done[i] = 0; m_t[i] = 0; m_mode[i] = 0; m_hold[i] = 1;
    end
  endtask

  task automatic model_step(input bit s, input bit a, input logic [1:0] md, input logic [23:0] h);
    int hv;
    for (int i = 0; i < 3; i++) begin
      if (m_done[i]) begin
        m_done[i] = 0;
      end else if (m_act[i]) begin
        if (a) m_act[i] = 0;
        else begin
          m_t[i]++;
          if (m_mode[i] == 0 && m_t[i] == NF[i] * m_hold[i]) begin
            m_act[i] = 0; m_done[i] = 1;
          end
        end
      end else if (s && !a) begin
        m_act[i]  = 1;
        m_t[i]    = 0;
        m_mode[i] = (md == 2'd1 || md == 2'd2) ? int'(md) : 0;
        hv = int'(h) & int'((64'd1 << HW[i]) - 64'd1);
        m_hold[i] = (hv == 0) ? 1 : hv;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int f;
    logic [63:0] em;
    for (int i = 0; i < 3; i++) begin
      f  = m_act[i] ? frame_at(NF[i], m_hold[i], m_mode[i], m_t[i]) : 0;
      em = m_act[i] ? (ROM[f] ^ {64{INV[i]}}) : 64'h0;
      check($sformatf("busy[%0d]", i),   64'(busy_o[i]), 64'(m_act[i]));
      check($sformatf("done[%0d]", i),   64'(done_o[i]), 64'(m_done[i]));
      check($sformatf("frame[%0d]", i),  64'(fidx_o[i]), 64'(f));
      check($sformatf("matrix[%0d]", i), mat_o[i], em);
    end
  endtask

  task automatic tick(input bit s, input bit a, input logic [1:0] md, input logic [23:0] h);
    start = s; abort = a; mode = md; hold = h;
    @(posedge clk);
    model_step(s, a, md, h);
    #1;
    check_model();
  endtask

  // Assert reset between edges; outputs must clear with no clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model();
    for (int i = 0; i < 3; i++) check($sformatf("async_rst_mat[%0d]", i), mat_o[i], 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model();
  endtask

  typedef struct {
    bit          s;
    bit          a;
    logic [1:0]  md;
    logic [23:0] h;
    bit          eb;
    bit          ed;
    logic [2:0]  ef;
  } vec_t;

  vec_t tbl [17];
  int   pp_exp [9] = '{0, 1, 2, 3, 2, 1, 0, 1, 2};

  initial begin
    int cycles;
    bit seen_done, seen_f3;
    logic [63:0] em;

    tbl[0]  = '{1, 1, 2'd0, 24'd5, 0, 0, 3'd0};  // start+abort in IDLE
    tbl[1]  = '{0, 0, 2'd0, 24'd5, 0, 0, 3'd0};
    tbl[2]  = '{1, 0, 2'd1, 24'd0, 1, 0, 3'd0};  // loop, hold 0 -> 1
    tbl[3]  = '{0, 0, 2'd1, 24'd0, 1, 0, 3'd1};
    tbl[4]  = '{1, 0, 2'd0, 24'd9, 1, 0, 3'd2};  // start in SHOW ignored
    tbl[5]  = '{0, 0, 2'd0, 24'd9, 1, 0, 3'd3};
    tbl[6]  = '{0, 0, 2'd0, 24'd9, 1, 0, 3'd4};
    tbl[7]  = '{0, 1, 2'd0, 24'd0, 0, 0, 3'd0};  // abort at frame 4
    tbl[8]  = '{1, 0, 2'd0, 24'd0, 1, 0, 3'd0};  // immediate restart, once
    for (int k = 9; k <= 14; k++) tbl[k] = '{0, 0, 2'd0, 24'd0, 1, 0, 3'(k - 8)};
    tbl[15] = '{0, 0, 2'd0, 24'd0, 0, 1, 3'd0};
    tbl[16] = '{0, 0, 2'd0, 24'd0, 0, 0, 3'd0};

    rst = 1'b1; start = 0; abort = 0; mode = 0; hold = 0;
    model_reset();
    #1;
    check_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model();

    for (int k = 0; k < 17; k++) begin
      tick(tbl[k].s, tbl[k].a, tbl[k].md, tbl[k].h);
      em = tbl[k].eb ? ROM[tbl[k].ef] : 64'h0;
      $display("vec %0d: busy=%0b done=%0b frame=%0d", k, busy_o[0], done_o[0], fidx_o[0]);
      check($sformatf("vec%0d_busy", k),  64'(busy_o[0]), 64'(tbl[k].eb));
      check($sformatf("vec%0d_done", k),  64'(done_o[0]), 64'(tbl[k].ed));
      check($sformatf("vec%0d_frame", k), 64'(fidx_o[0]), 64'(tbl[k].ef));
      check($sformatf("vec%0d_mat", k),   mat_o[0], em);
    end

    // Once, hold 3: start on first edge after reset, done 21 cycles later.
    do_reset();
    tick(1, 0, 2'd0, 24'd3);
    check("first_edge_start", 64'(busy_o[0]), 64'd1);
    cycles = 0;
    while (!done_o[0] && cycles < 100) begin
      tick(0, 0, 2'd0, 24'd3);
      cycles++;
    end
    check("done_latency", 64'(cycles), 64'd21);
    tick(0, 0, 2'd0, 24'd3);
    check("after_done_mat", mat_o[0], 64'h0);
    check("after_done_pulse", 64'(done_o[0]), 64'd0);
    $display("seq once: done after %0d cycles", cycles);

    // Loop, hold 2: no done, frame 3 row 6 is 7E.
    tick(1, 0, 2'd1, 24'd2);
    seen_done = 0; seen_f3 = 0;
    for (int k = 0; k < 17; k++) begin
      if (fidx_o[0] == 3'd3 && !seen_f3) begin
        seen_f3 = 1;
        check("f3_row6", 64'(mat_o[0][55:48]), 64'h7E);
      end
      tick(0, 0, 2'd2, 24'd7);
      if (done_o[0]) seen_done = 1;
    end
    check("loop_no_done", 64'(seen_done), 64'd0);
    check("loop_wrapped_to", 64'(fidx_o[0]), 64'd1);
    tick(0, 1, 2'd0, 24'd0);
    $display("seq loop: ended at abort");

    // Ping-pong, hold 1, NFRAMES=4 instance.
    tick(1, 0, 2'd2, 24'd1);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("pingpong%0d", k), 64'(fidx_o[1]), 64'(pp_exp[k]));
      tick(0, 0, 2'd0, 24'd1);
    end
    tick(0, 1, 2'd0, 24'd0);
    $display("seq pingpong: checked 9 frames");

    // Reset pulse in the middle of frame 2.
    tick(1, 0, 2'd0, 24'd3);
    cycles = 0;
    while (fidx_o[0] != 3'd2 && cycles < 20) begin
      tick(0, 0, 2'd0, 24'd3);
      cycles++;
    end
    check("reached_frame2", 64'(fidx_o[0]), 64'd2);
    do_reset();
    check("rst_busy", 64'(busy_o[0]), 64'd0);
    check("rst_frame", 64'(fidx_o[0]), 64'd0);
    $display("seq reset: mid-frame reset applied");

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      bit s, a;
      s = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 39) == 0);
      if (s) $display("rand %0d: start request mode/hold drawn", k);
      tick(s, a, 2'($urandom_range(0, 3)), 24'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cc_transition_animator.md
CC_TRANSITION_ANIMATOR -- requirements
Module: cc_transition_animator

Interface
REQ-001 The block SHALL have parameter NFRAMES, default 7, meaning the number of frames played, legal range 1..7 (frames 0..NFRAMES-1).
REQ-002 The block SHALL have parameter HOLD_W, default 24, meaning the width of the per-frame hold count.
REQ-003 The block SHALL have parameter INVERT, default 0, meaning that when 1 every lit-frame bit is inverted before it is registered.
REQ-004 Port: transition_animator_CLOCK_50  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: transition_animator_RESET_InHigh  in  1  asynchronous, active-high reset.
REQ-006 Port: transition_animator_start_in  in  1  single-cycle start request.
REQ-007 Port: transition_animator_abort_in  in  1  stop playback immediately.
REQ-008 Port: transition_animator_mode_in  in  2  playback mode: 00 once, 01 loop, 10 ping-pong, 11 treated as once.
REQ-009 Port: transition_animator_hold_in  in  HOLD_W  clock cycles each frame is shown.
REQ-010 Port: transition_animator_matrix_bus_out  out  64  8x8 image; row r occupies bits [8r+7:8r], with row 7 as the top row.
REQ-011 Port: transition_animator_frame_idx_out  out  3  index of the frame currently shown.
REQ-012 Port: transition_animator_busy_out  out  1  high while the block is in SHOW.
REQ-013 Port: transition_animator_done_out  out  1  one-cycle pulse at the end of a once-mode playback.

Function
REQ-014 The internal frame ROM SHALL hold the following hex values, listed as rows 7..0:
- f0: 20 30 38 3C 3C 38 30 20
- f1: 66 99 89 89 B9 99 99 66
- f2: 81 42 24 18 18 24 42 81
- f3: FF 7E 3C 18 18 18 3C FF
- f4: FF 18 18 18 18 18 18 FF
- f5: FF 66 66 66 66 66 66 FF
- f6: FF 5A 5A 5A 5A 5A 5A FF
REQ-015 The FSM SHALL have exactly three states:
- IDLE
- SHOW
- DONE
REQ-016 In IDLE, a start with abort low SHALL:
- latch mode and hold; a hold of 0 is treated as 1;
- clear frame_idx to 0, clear the hold counter, and set direction to up;
- enter SHOW on that edge.
REQ-017 Start latency SHALL be one cycle: start sampled at edge k gives busy=1 and frame 0 on matrix_bus_out after edge k.
REQ-018 In SHOW, each frame SHALL stay visible for exactly hold cycles. At that point the next frame is selected and the hold counter is cleared.
REQ-019 Once mode: expiry of frame NFRAMES-1 SHALL move the FSM to DONE.
REQ-020 Loop mode: frame NFRAMES-1 SHALL wrap to frame 0, and playback SHALL never end on its own.
REQ-021 Ping-pong mode: the sequence SHALL be 0,1,..,N-1,N-2,..,0,1,..; end frames are not repeated, and playback never ends on its own.
REQ-022 When NFRAMES=1, loop and ping-pong SHALL hold frame 0 indefinitely, and once mode SHALL go to DONE after hold cycles.
REQ-023 DONE SHALL last exactly one cycle, during which done=1, busy=0 and matrix=0; the FSM then enters IDLE.
REQ-024 Abort in SHOW SHALL return the FSM to IDLE on the next edge with matrix=0 and frame_idx=0, and no done pulse.
REQ-025 Start while in SHOW or DONE SHALL be ignored; it does not restart playback.
REQ-026 If start and abort are both high in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-027 Changes to mode_in or hold_in during SHOW SHALL have no effect until the next start.
REQ-028 matrix_bus_out SHALL be registered and equal ROM[frame_idx], XOR all-ones when INVERT=1, in SHOW, and 0 in IDLE and DONE.
REQ-029 The hold counter SHALL be HOLD_W bits wide and SHALL never wrap, because it is cleared on every frame advance.

Reset
REQ-030 While reset is high, the block SHALL asynchronously force:
- state=IDLE;
- matrix=0, frame_idx=0, busy=0, done=0;
- hold counter=0, direction=up;
- latched mode=00.
REQ-031 Reset asserted during SHOW or DONE SHALL abandon playback with no done pulse.
REQ-032 After reset deassertion, the block SHALL accept a start on the first rising edge.

Verification
REQ-033 Reset, then once, hold=3, NFRAMES=7 -> frames 0..6 shown 3 cycles each, a one-cycle done 21 cycles after busy rises, then matrix=0.
REQ-034 Loop, hold=2 -> frame sequence 0..6,0,1; the frame 3 row 6 bits [55:48]=7E; no done.
REQ-035 Ping-pong, hold=1, NFRAMES=4 -> frame_idx sequence 0,1,2,3,2,1,0,1,2.
REQ-036 Abort at frame 4 -> next cycle busy=0, matrix=0, no done; a start sampled at edge k with abort low is accepted at edge k.
REQ-037 Start with hold=0 -> each frame shown 1 cycle; start during SHOW -> sequence continues unchanged.
REQ-038 Start+abort in IDLE -> stays IDLE; reset pulse mid-frame 2 -> all outputs 0 immediately, with no clock edge required.
